// File: rtl/instruc_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruc_queue_pkg
// Description : Shared constants for the instruction queue: default word
//               width, default queue depth and the NOP encoding used by
//               benches and the decode stall path.
// Revision    : 1.0 - initial release
// ============================================================================
package instruc_queue_pkg;

    localparam int INSTR_W       = 16;
    localparam int INSTR_Q_DEPTH = 4;

    // Encoding decode substitutes when it stalls on an empty queue.
    localparam logic [INSTR_W-1:0] NOP = '0;

endpackage : instruc_queue_pkg
`default_nettype wire

// File: rtl/instruc_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : instruc_queue_mem
// Description : DEPTH x WIDTH register array with one synchronous write port
//               and one combinational read port. No reset; contents are
//               only meaningful where the owning queue says so.
// Revision    : 1.0 - initial release
// ============================================================================
module instruc_queue_mem
    import instruc_queue_pkg::*;
#(
    parameter int WIDTH = INSTR_W,
    parameter int DEPTH = INSTR_Q_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : instruc_queue_mem
`default_nettype wire

// File: rtl/instruc_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruc_queue
// Description : DEPTH-entry FIFO of instruction words between fetch and
//               decode with ready/valid on both sides, flush for taken
//               branches, and a registered head word on `out`.
// Revision    : 1.0 - initial release
// ============================================================================
module instruc_queue
    import instruc_queue_pkg::*;
#(
    parameter int WIDTH = INSTR_W,
    parameter int DEPTH = INSTR_Q_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] next_head_addr;
    logic [WIDTH-1:0] next_head_word;
    logic [WIDTH-1:0] out_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshake flags depend only on registered count, never on out_ready.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Flush wins over both sides, so a word offered during flush is dropped.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // The word behind the current head becomes the head after a pop.
    assign next_head_addr = rd_ptr + PTR_ONE;

    instruc_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (next_head_addr),
        .rdata (next_head_word)
    );

    // Select the next registered head. With one word held, a pop either
    // empties the queue (out returns to 0) or hands over to the word being
    // pushed this edge, which is not yet in the array.
    always_comb begin
        out_next = out;
        if (pop) begin
            if (count == ONE_COUNT) begin
                out_next = push ? in : '0;
            end else begin
                out_next = next_head_word;
            end
        end else if (empty && push) begin
            out_next = in;
        end
    end

    // Pointers, occupancy and head register; reset over flush over push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
            out <= out_next;
        end
    end

endmodule : instruc_queue
`default_nettype wire
